// File: rtl/req_pending_latch.sv
// Sticky request capture for eight asynchronous lines, serviced highest index first
// through a registered valid/ready index port, with per-line overrun tracking.
module req_pending_latch #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_in,
   input  logic [N-1:0]     mask,
   input  logic             clear_all,
   output logic [N-1:0]     pend_out,
   output logic             idx_valid,
   output logic [IDX_W-1:0] idx,
   input  logic             idx_ready,
   output logic [N-1:0]     overrun
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_OFFER = 1'b1;

   logic [N-1:0]     s1_reg;
   logic [N-1:0]     s2_reg;
   logic [N-1:0]     s3_reg;
   logic [N-1:0]     pend_reg;
   logic [N-1:0]     pend_next;
   logic [N-1:0]     ovr_reg;
   logic [N-1:0]     ovr_next;
   logic [N-1:0]     rise;
   logic [N-1:0]     acc_vec;
   logic [N-1:0]     cand;
   logic [0:0]       state_reg;
   logic [0:0]       state_next;
   logic [IDX_W-1:0] idx_reg;
   logic [IDX_W-1:0] idx_next;
   logic [IDX_W-1:0] sel;
   logic             accept;

   // Two-flop synchronizer plus a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_reg <= '0;
         s2_reg <= '0;
         s3_reg <= '0;
      end else begin
         s1_reg <= req_in;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign rise   = s2_reg & ~s3_reg;
   assign accept = (state_reg == ST_OFFER) && idx_ready;
   assign cand   = pend_reg & ~mask;

   // A rise beats a same-cycle accept of that bit, so the line is re-offered.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
         assign acc_vec[gi]   = accept && (idx_reg == IDX_W'(gi));
         assign pend_next[gi] = clear_all   ? 1'b0 :
                                rise[gi]    ? 1'b1 :
                                acc_vec[gi] ? 1'b0 : pend_reg[gi];
         assign ovr_next[gi]  = clear_all ? 1'b0 :
                                (ovr_reg[gi] | (rise[gi] & pend_reg[gi] & ~acc_vec[gi]));
      end
   endgenerate

   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) begin
         if (cand[i]) sel = IDX_W'(i);
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         ST_IDLE: begin
            if ((cand != '0) && !clear_all) begin
               idx_next   = sel;
               state_next = ST_OFFER;
            end
         end
         default: begin
            if (clear_all || accept) state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg  <= '0;
         ovr_reg   <= '0;
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
      end else begin
         pend_reg  <= pend_next;
         ovr_reg   <= ovr_next;
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   assign pend_out  = pend_reg;
   assign overrun   = ovr_reg;
   assign idx_valid = (state_reg == ST_OFFER);
   assign idx       = idx_reg;

endmodule

// File: tb/tb_req_pending_latch.sv
// Directed scenarios plus a randomized run against a word-level reference model.
module tb_req_pending_latch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_in = '0;
   logic [7:0] mask = '0;
   logic       clear_all = 1'b0;
   logic       idx_ready = 1'b0;
   logic [7:0] pend_out;
   logic [7:0] overrun;
   logic       idx_valid;
   logic [2:0] idx;

   int checks = 0;
   int errors = 0;

   // Reference model: request history, pending word, overrun word, offered index (-1 = none)
   logic [7:0] m_s1, m_s2, m_s3, m_pend, m_ovr;
   int         m_offer;

   req_pending_latch #(.N(8), .IDX_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .clear_all(clear_all),
      .pend_out(pend_out), .idx_valid(idx_valid), .idx(idx), .idx_ready(idx_ready),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic int highest(input logic [7:0] w);
      int h = -1;
      for (int i = 0; i < 8; i++) if (w[i]) h = i;
      return h;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_s3 = '0; m_pend = '0; m_ovr = '0; m_offer = -1;
   endtask

   // Advance one clock: compute model next state from current inputs, then sample DUT at edge+1.
   task automatic step();
      logic [7:0] rise, acc_bit, n_pend, n_ovr;
      int         n_offer;
      rise    = m_s2 & ~m_s3;
      acc_bit = (m_offer >= 0 && idx_ready) ? (8'd1 << m_offer) : 8'd0;
      if (clear_all) begin
         n_pend  = '0;
         n_ovr   = '0;
         n_offer = -1;
      end else begin
         n_pend = (m_pend & ~acc_bit) | rise;
         n_ovr  = m_ovr | (rise & m_pend & ~acc_bit);
         if (m_offer >= 0) n_offer = (acc_bit != 0) ? -1 : m_offer;
         else              n_offer = highest(m_pend & ~mask);
      end
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = req_in;
         m_pend = n_pend; m_ovr = n_ovr; m_offer = n_offer;
      end
      #1;
   endtask

   task automatic wait_offer(input string name);
      for (int k = 0; k < 20 && !idx_valid; k++) step();
      checks++;
      if (idx_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout idx_valid got %b expected 1", name, idx_valid);
      end
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      checks++;
      if ({pend_out, overrun, idx_valid, idx} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 00000", {pend_out, overrun, idx_valid, idx});
      end
      step(); step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({pend_out, idx_valid} !== 9'h0) begin
         errors++;
         $display("FAIL reset_release got %h expected 000", {pend_out, idx_valid});
      end
   endtask

   task automatic test_single();
      req_in = 8'h20;
      step(); step(); step();
      checks++;
      if (pend_out !== 8'h20 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pend pend_out=%h valid=%b expected 20/0", pend_out, idx_valid);
      end
      step();
      for (int c = 0; c < 11; c++) begin
         checks++;
         if (idx_valid !== 1'b1 || idx !== 3'd5 || pend_out !== 8'h20) begin
            errors++;
            $display("FAIL single_hold cyc %0d valid=%b idx=%0d pend=%h expected 1/5/20",
                     c, idx_valid, idx, pend_out);
         end
         step();
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      req_in = 8'h00;
      checks++;
      if (pend_out !== 8'h00 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_accept pend=%h valid=%b expected 00/0", pend_out, idx_valid);
      end
      step(); step(); step();
   endtask

   task automatic test_back_to_back();
      int         offers[$];
      logic [7:0] pends[$];
      logic       prev_valid;
      idx_ready = 1'b1;
      req_in = 8'h92;
      prev_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (idx_valid) offers.push_back(int'(idx));
         if (pend_out != 8'h00 && (pends.size() == 0 || pends[$] != pend_out)) pends.push_back(pend_out);
         if (pend_out == 8'h00 && pends.size() != 0 && pends[$] != 8'h00) pends.push_back(pend_out);
         checks++;
         if (prev_valid && idx_valid) begin
            errors++;
            $display("FAIL b2b_bubble cyc %0d valid high twice in a row", c);
         end
         prev_valid = idx_valid;
      end
      checks++;
      if (offers.size() != 3 || offers[0] != 7 || offers[1] != 4 || offers[2] != 1) begin
         errors++;
         $display("FAIL b2b_offers got %p expected '{7,4,1}", offers);
      end
      checks++;
      if (pends.size() != 4 || pends[0] != 8'h92 || pends[1] != 8'h12 ||
          pends[2] != 8'h02 || pends[3] != 8'h00) begin
         errors++;
         $display("FAIL b2b_pend got %p expected '{92,12,02,00}", pends);
      end
      idx_ready = 1'b0;
      req_in = 8'h00;
      step(); step(); step();
   endtask

   task automatic test_no_preempt();
      req_in = 8'h08;
      wait_offer("preempt");
      req_in = 8'h48;
      for (int c = 0; c < 6; c++) begin
         step();
         checks++;
         if (idx_valid !== 1'b1 || idx !== 3'd3) begin
            errors++;
            $display("FAIL preempt_hold cyc %0d valid=%b idx=%0d expected 1/3", c, idx_valid, idx);
         end
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      checks++;
      if (idx_valid !== 1'b0 || pend_out !== 8'h40) begin
         errors++;
         $display("FAIL preempt_bubble valid=%b pend=%h expected 0/40", idx_valid, pend_out);
      end
      step();
      checks++;
      if (idx_valid !== 1'b1 || idx !== 3'd6) begin
         errors++;
         $display("FAIL preempt_next valid=%b idx=%0d expected 1/6", idx_valid, idx);
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      req_in = 8'h00;
      step(); step(); step();
   endtask

   task automatic test_overrun();
      req_in = 8'h04;
      wait_offer("ovr");
      req_in = 8'h00; step(); step(); step();
      req_in = 8'h04; step(); step(); step();
      checks++;
      if (overrun !== 8'h04 || pend_out !== 8'h04) begin
         errors++;
         $display("FAIL overrun_set overrun=%h pend=%h expected 04/04", overrun, pend_out);
      end
      clear_all = 1'b1; step(); clear_all = 1'b0;
      checks++;
      if (overrun !== 8'h00 || pend_out !== 8'h00 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear overrun=%h pend=%h valid=%b expected 00/00/0",
                  overrun, pend_out, idx_valid);
      end
      req_in = 8'h00; step(); step(); step();
      req_in = 8'h04;
      wait_offer("ovr2");
      req_in = 8'h00; step(); step(); step();
      req_in = 8'h04; step(); step();
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      checks++;
      if (overrun !== 8'h00 || pend_out !== 8'h04 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_align overrun=%h pend=%h valid=%b expected 00/04/0",
                  overrun, pend_out, idx_valid);
      end
      step();
      checks++;
      if (idx_valid !== 1'b1 || idx !== 3'd2) begin
         errors++;
         $display("FAIL overrun_reoffer valid=%b idx=%0d expected 1/2", idx_valid, idx);
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      req_in = 8'h00; step(); step(); step();
   endtask

   task automatic test_mask();
      mask = 8'hF0;
      req_in = 8'h81;
      wait_offer("mask");
      checks++;
      if (idx !== 3'd0 || pend_out !== 8'h81) begin
         errors++;
         $display("FAIL mask_offer idx=%0d pend=%h expected 0/81", idx, pend_out);
      end
      mask = 8'h00; step();
      checks++;
      if (idx_valid !== 1'b1 || idx !== 3'd0) begin
         errors++;
         $display("FAIL mask_hold valid=%b idx=%0d expected 1/0", idx_valid, idx);
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      step();
      checks++;
      if (idx_valid !== 1'b1 || idx !== 3'd7 || pend_out !== 8'h80) begin
         errors++;
         $display("FAIL mask_unmask valid=%b idx=%0d pend=%h expected 1/7/80", idx_valid, idx, pend_out);
      end
      idx_ready = 1'b1; step(); idx_ready = 1'b0;
      req_in = 8'h00; step(); step(); step();
   endtask

   task automatic test_clear();
      req_in = 8'h08;
      wait_offer("clear");
      req_in = 8'h00; step(); step(); step();
      req_in = 8'h08; step(); step(); step();
      req_in = 8'h0A; step(); step();
      clear_all = 1'b1; step(); clear_all = 1'b0;
      checks++;
      if (pend_out !== 8'h00 || overrun !== 8'h00 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_edge pend=%h overrun=%h valid=%b expected 00/00/0",
                  pend_out, overrun, idx_valid);
      end
      step(); step(); step();
      checks++;
      if (pend_out !== 8'h00 || idx_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_lost pend=%h valid=%b expected 00/0", pend_out, idx_valid);
      end
   endtask

   task automatic test_async_reset();
      req_in = 8'h00; step(); step(); step();
      req_in = 8'h10;
      wait_offer("areset");
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pend_out, overrun, idx_valid, idx} !== 20'h0) begin
         errors++;
         $display("FAIL async_reset got %h expected 00000", {pend_out, overrun, idx_valid, idx});
      end
      model_reset();
      req_in = 8'h00;
      @(negedge clk); #1;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         req_in    = req_in ^ ($urandom() & $urandom() & $urandom());
         if ($urandom_range(0, 15) == 0) mask = $urandom();
         idx_ready = ($urandom_range(0, 2) != 0);
         clear_all = ($urandom_range(0, 63) == 0);
         step();
         checks++;
         if (pend_out !== m_pend || overrun !== m_ovr || idx_valid !== (m_offer >= 0) ||
             (m_offer >= 0 && int'(idx) != m_offer)) begin
            errors++;
            $display("FAIL random cyc %0d pend=%h/%h ovr=%h/%h valid=%b/%b idx=%0d/%0d (got/expected)",
                     c, pend_out, m_pend, overrun, m_ovr, idx_valid, (m_offer >= 0), idx, m_offer);
         end
      end
      clear_all = 1'b0;
      idx_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_no_preempt();
      test_overrun();
      test_mask();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
